// File: rtl/pipe_register_m.sv
// pipe_register_m: DEPTH-stage valid/ready pipeline register.
// Each stage holds WIDTH data bits plus a valid bit. Bubbles are compacted:
// any valid stage moves forward whenever the stage ahead is empty or moving.
// The last stage drives q/q_valid straight from flops.
// Optional feature: define PIPE_REGISTER_FLUSH_EN to add a synchronous
// active-high flush input that empties the pipe while keeping data bits.
module pipe_register_m #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
`ifdef PIPE_REGISTER_FLUSH_EN
    input  logic             flush,
`endif
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic             d_ready,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    input  logic             q_ready,
    output logic [CW-1:0]    count
);

    logic flush_w;
`ifdef PIPE_REGISTER_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [DEPTH-1:0] adv;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             room0;
    logic             in_xfer;
    logic             out_xfer;

    // Advance chain: walk from the output back to stage 0; a stage has room
    // to receive when the stage is empty or itself moving on.
    always_comb begin
        logic room;
        room = q_ready;
        adv  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            adv[i] = valid_q[i] && room;
            room   = !valid_q[i] || room;
        end
        room0 = room;
    end

    assign d_ready  = !rst && !flush_w && room0;
    assign in_xfer  = d_valid && d_ready;
    assign out_xfer = adv[DEPTH-1];

    // Next-state for stage contents and occupancy count
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        count_d = count_q;

        // Stage 0 loads only on an accepted input, so X on d is never captured
        if (in_xfer) begin
            valid_d[0] = 1'b1;
            data_d[0]  = d;
        end else if (adv[0]) begin
            valid_d[0] = 1'b0;
        end

        for (int i = 1; i < DEPTH; i++) begin
            if (adv[i-1]) begin
                valid_d[i] = 1'b1;
                data_d[i]  = data_q[i-1];
            end else if (adv[i]) begin
                valid_d[i] = 1'b0;
            end
        end

        if (in_xfer && !out_xfer) begin
            count_d = count_q + CW'(1);
        end else if (!in_xfer && out_xfer) begin
            count_d = count_q - CW'(1);
        end

        // Flush empties the pipe but leaves the data bits in place
        if (flush_w) begin
            valid_d = '0;
            count_d = '0;
        end
    end

    // State registers with synchronous reset (reset overrides flush)
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign q       = data_q[DEPTH-1];
    assign q_valid = valid_q[DEPTH-1];
    assign count   = count_q;

endmodule

// File: tb/tb_pipe_register_m.sv
// Testbench for pipe_register_m (WIDTH=8, DEPTH=3).
// Stimulus pushes hand-computed expected words and arrival cycles into a
// scoreboard; a negedge monitor pops and compares on every output transfer.
module tb_pipe_register_m;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 3;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] d;
    logic             d_valid;
    logic             d_ready;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             q_ready;
    logic [CW-1:0]    count;
`ifdef PIPE_REGISTER_FLUSH_EN
    logic             flush;
`endif

    pipe_register_m #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
`ifdef PIPE_REGISTER_FLUSH_EN
        .flush  (flush),
`endif
        .d      (d),
        .d_valid(d_valid),
        .d_ready(d_ready),
        .q      (q),
        .q_valid(q_valid),
        .q_ready(q_ready),
        .count  (count)
    );

    typedef struct {
        logic [WIDTH-1:0] data;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic expect_word(input logic [WIDTH-1:0] data, input int at_cyc);
        exp_t e;
        e.data = data;
        e.cyc  = at_cyc;
        sb.push_back(e);
    endtask

    // Monitor: every output transfer must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!rst && q_valid && q_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got %0h expected no word (cycle %0d)", q, cyc);
            end else begin
                e = sb.pop_front();
                check("q_data", 64'(q), 64'(e.data));
                check("q_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int s;
        rst     = 1'b1;
        d_valid = 1'b1;
        d       = 8'hFF;
        q_ready = 1'b0;
`ifdef PIPE_REGISTER_FLUSH_EN
        flush   = 1'b0;
`endif
        // Reset: two cycles with a word offered, nothing accepted
        tick();
        tick();
        at_neg();
        check("rst_d_ready", 64'(d_ready), 64'd0);
        check("rst_q_valid", 64'(q_valid), 64'd0);
        check("rst_q", 64'(q), 64'h00);
        check("rst_count", 64'(count), 64'd0);
        rst     = 1'b0;
        d_valid = 1'b0;
        d       = 8'hxx;
        tick();
        at_neg();
        check("post_rst_count", 64'(count), 64'd0);
        check("post_rst_d_ready", 64'(d_ready), 64'd1);

        // Streaming: three words, latency DEPTH cycles each
        tick();
        q_ready = 1'b1;
        d_valid = 1'b1;
        d = 8'hAA; expect_word(8'hAA, cyc + 3); tick();
        d = 8'h55; expect_word(8'h55, cyc + 3); tick();
        d = 8'h0F; expect_word(8'h0F, cyc + 3); tick();
        d_valid = 1'b0;
        d       = 8'hxx;
        at_neg();
        check("stream_count_peak", 64'(count), 64'd3);
        repeat (3) tick();
        at_neg();
        check("stream_drained", 64'(count), 64'd0);

        // Backpressure: fill with q_ready low, fourth word held off
        q_ready = 1'b0;
        d_valid = 1'b1;
        d = 8'h11; tick();
        d = 8'h22; tick();
        d = 8'h33; tick();
        d = 8'h44;
        at_neg();
        check("bp_d_ready_full", 64'(d_ready), 64'd0);
        check("bp_count_full", 64'(count), 64'd3);
        check("bp_q_head", 64'(q), 64'h11);
        tick();
        at_neg();
        check("bp_q_stable", 64'(q), 64'h11);
        check("bp_q_valid_stable", 64'(q_valid), 64'd1);
        tick();
        q_ready = 1'b1;
        expect_word(8'h11, cyc);
        expect_word(8'h22, cyc + 1);
        expect_word(8'h33, cyc + 2);
        expect_word(8'h44, cyc + 3);
        at_neg();
        check("bp_d_ready_release", 64'(d_ready), 64'd1);
        tick();
        d_valid = 1'b0;
        d       = 8'hxx;
        repeat (4) tick();
        at_neg();
        check("bp_drained", 64'(count), 64'd0);

        // Full throughput: simultaneous pop and push while full
        q_ready = 1'b0;
        d_valid = 1'b1;
        s = cyc;
        d = 8'h11; tick();
        d = 8'h22; tick();
        d = 8'h33; tick();
        expect_word(8'h11, s + 3);
        expect_word(8'h22, s + 4);
        expect_word(8'h33, s + 5);
        expect_word(8'h66, s + 6);
        q_ready = 1'b1;
        d       = 8'h66;
        at_neg();
        check("ft_d_ready", 64'(d_ready), 64'd1);
        check("ft_count_before", 64'(count), 64'd3);
        tick();
        d_valid = 1'b0;
        d       = 8'hxx;
        at_neg();
        check("ft_count_after", 64'(count), 64'd3);
        check("ft_q_next", 64'(q), 64'h22);
        repeat (4) tick();

        // Reset mid-operation: contents discarded, word offered in reset ignored
        q_ready = 1'b0;
        d_valid = 1'b1;
        d = 8'hA1; tick();
        d = 8'hA2; tick();
        d_valid = 1'b0;
        d       = 8'hxx;
        at_neg();
        check("mid_count_two", 64'(count), 64'd2);
        tick();
        rst     = 1'b1;
        d_valid = 1'b1;
        d       = 8'hEE;
        tick();
        rst     = 1'b0;
        d_valid = 1'b0;
        d       = 8'hxx;
        at_neg();
        check("mid_rst_count", 64'(count), 64'd0);
        check("mid_rst_q_valid", 64'(q_valid), 64'd0);
        check("mid_rst_q", 64'(q), 64'h00);
        tick();
        q_ready = 1'b1;
        d_valid = 1'b1;
        d       = 8'h77;
        expect_word(8'h77, cyc + 3);
        tick();
        d_valid = 1'b0;
        d       = 8'hxx;
        repeat (4) tick();

`ifdef PIPE_REGISTER_FLUSH_EN
        // Flush: empties the pipe, blocks input while high
        q_ready = 1'b0;
        d_valid = 1'b1;
        d = 8'hB1; tick();
        d = 8'hB2; tick();
        d = 8'hB3; tick();
        d_valid = 1'b0;
        d       = 8'hxx;
        at_neg();
        check("fl_count_full", 64'(count), 64'd3);
        tick();
        flush   = 1'b1;
        d_valid = 1'b1;
        d       = 8'hEE;
        at_neg();
        check("fl_d_ready", 64'(d_ready), 64'd0);
        tick();
        flush   = 1'b0;
        d_valid = 1'b0;
        d       = 8'hxx;
        at_neg();
        check("fl_count", 64'(count), 64'd0);
        check("fl_q_valid", 64'(q_valid), 64'd0);
        tick();
        q_ready = 1'b1;
        d_valid = 1'b1;
        d       = 8'h99;
        expect_word(8'h99, cyc + 3);
        tick();
        d_valid = 1'b0;
        d       = 8'hxx;
        repeat (4) tick();
`endif

        at_neg();
        check("final_count", 64'(count), 64'd0);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
